// File: rtl/reset_pkg.sv
// Shared state encoding and cause-bit positions for the reset sequencer.
package reset_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam int CAUSE_RST  = 0;
  localparam int CAUSE_PLL  = 1;
  localparam int CAUSE_EXT  = 2;
  localparam int CAUSE_SW   = 3;
  localparam int NUM_CAUSES = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// Two-flop synchroniser followed by a level debouncer: the output follows the
// synchronised input only after it has held a new level for CYCLES samples.
module sync_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int              CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
      // Any sample matching the current output restarts the run.
      if (sync_b == dout) begin
        cnt <= '0;
      end else if (cnt >= LAST) begin
        dout <= sync_b;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: asserts all domain resets on any cause, then
// releases them in index order (resetn[1] is the CPU reset).
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int CHANNELS        = 3,
  parameter int HOLD_CYCLES     = 8,
  parameter int STAGE_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  ext_req,
  input  logic                  sw_req,
  input  logic                  cause_clr,
  output logic [CHANNELS-1:0]   resetn,
  output logic                  done,
  output logic [NUM_CAUSES-1:0] cause
);

  localparam int CNT_MAX = max3(HOLD_CYCLES, STAGE_CYCLES, DEBOUNCE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);

  localparam logic [1:0] S_ASSERT  = ASSERT;
  localparam logic [1:0] S_RELEASE = RELEASE;
  localparam logic [1:0] S_RUN     = RUN;

  logic                  pll_meta;
  logic                  pll_sync;
  logic                  ext_deb;
  logic [NUM_CAUSES-1:0] act;
  logic                  any_cause;
  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [CHANNELS-1:0]   next_rn;

  sync_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_ext_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (ext_req),
    .dout (ext_deb)
  );

  always_comb begin
    act            = '0;
    act[CAUSE_RST] = rst;
    act[CAUSE_PLL] = ~pll_sync;
    act[CAUSE_EXT] = ext_deb;
    act[CAUSE_SW]  = sw_req;
    any_cause      = |act;
    next_rn        = (resetn << 1) | CHANNELS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // PLL synchroniser resets to "locked" so rst alone times the first release.
      pll_meta <= 1'b1;
      pll_sync <= 1'b1;
      state    <= S_ASSERT;
      cnt      <= '0;
      resetn   <= '0;
      done     <= 1'b0;
      cause    <= 4'b0001;
    end else begin
      pll_meta <= pll_locked;
      pll_sync <= pll_meta;
      cause    <= (cause_clr ? '0 : cause) | act;

      if (any_cause) begin
        state  <= S_ASSERT;
        cnt    <= '0;
        resetn <= '0;
        done   <= 1'b0;
      end else begin
        case (state)
          S_ASSERT: begin
            if (cnt >= HOLD_LAST) begin
              cnt    <= '0;
              resetn <= CHANNELS'(1);
              if (CHANNELS == 1) begin
                done  <= 1'b1;
                state <= S_RUN;
              end else begin
                state <= S_RELEASE;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_RELEASE: begin
            if (cnt >= STAGE_LAST) begin
              cnt    <= '0;
              resetn <= next_rn;
              if (next_rn[CHANNELS-1]) begin
                done  <= 1'b1;
                state <= S_RUN;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_RUN: begin
            cnt <= '0;
          end
          default: begin
            state  <= S_ASSERT;
            cnt    <= '0;
            resetn <= '0;
            done   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer (3-channel instance plus a 1-channel instance).
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst1 = 1'b1;
  logic       pll_locked = 1'b1;
  logic       ext_req = 1'b0;
  logic       sw_req = 1'b0;
  logic       cause_clr = 1'b0;
  logic [2:0] resetn;
  logic       done;
  logic [3:0] cause;
  logic [0:0] resetn1;
  logic       done1;
  logic [3:0] cause1;

  int edge_n = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  typedef struct {
    int         e;
    logic [2:0] rn;
    logic       dn;
    logic [3:0] cs;
  } exp_t;

  exp_t ev_q[$];
  exp_t snap_q[$];
  exp_t ev1_q[$];
  logic [3:0] prev  = 4'b0000;
  logic [1:0] prev1 = 2'b00;

  reset_sequencer #(
    .CHANNELS(3), .HOLD_CYCLES(8), .STAGE_CYCLES(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .ext_req(ext_req),
    .sw_req(sw_req), .cause_clr(cause_clr), .resetn(resetn), .done(done), .cause(cause)
  );

  reset_sequencer #(
    .CHANNELS(1), .HOLD_CYCLES(8), .STAGE_CYCLES(4), .DEBOUNCE_CYCLES(4)
  ) dut1 (
    .clk(clk), .rst(rst1), .pll_locked(pll_locked), .ext_req(1'b0),
    .sw_req(1'b0), .cause_clr(1'b0), .resetn(resetn1), .done(done1), .cause(cause1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void push_ev(input int e, input logic [2:0] rn, input logic dn);
    exp_t x;
    x.e = e; x.rn = rn; x.dn = dn; x.cs = 4'b0000;
    ev_q.push_back(x);
  endfunction

  function automatic void push_seq(input int e);
    push_ev(e + 8,  3'b001, 1'b0);
    push_ev(e + 12, 3'b011, 1'b0);
    push_ev(e + 16, 3'b111, 1'b1);
  endfunction

  function automatic void push_snap(input int e, input logic [2:0] rn, input logic dn,
                                    input logic [3:0] cs);
    exp_t x;
    x.e = e; x.rn = rn; x.dn = dn; x.cs = cs;
    snap_q.push_back(x);
  endfunction

  function automatic void push_ev1(input int e, input logic rn, input logic dn,
                                   input logic [3:0] cs);
    exp_t x;
    x.e = e; x.rn = {2'b00, rn}; x.dn = dn; x.cs = cs;
    ev1_q.push_back(x);
  endfunction

  // Monitor for the 3-channel instance: every output change must match the queue head.
  always @(negedge clk) begin
    exp_t x;
    if (edge_n > 0) begin
      if ({resetn, done} !== prev) begin
        n_cmp++;
        if (ev_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: edge %0d got resetn=%b done=%b, required no change",
                   edge_n, resetn, done);
        end else begin
          x = ev_q.pop_front();
          if (x.e != edge_n || x.rn !== resetn || x.dn !== done) begin
            n_bad++;
            $display("FAIL seq_event: got edge %0d resetn=%b done=%b, required edge %0d resetn=%b done=%b",
                     edge_n, resetn, done, x.e, x.rn, x.dn);
          end
        end
      end else if (ev_q.size() > 0 && ev_q[0].e <= edge_n) begin
        x = ev_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_event: edge %0d got resetn=%b done=%b, required resetn=%b done=%b",
                 edge_n, resetn, done, x.rn, x.dn);
      end
      prev = {resetn, done};
      while (snap_q.size() > 0 && snap_q[0].e <= edge_n) begin
        x = snap_q.pop_front();
        n_cmp++;
        if (x.e != edge_n || {resetn, done, cause} !== {x.rn, x.dn, x.cs}) begin
          n_bad++;
          $display("FAIL snapshot: edge %0d got resetn=%b done=%b cause=%b, required edge %0d resetn=%b done=%b cause=%b",
                   edge_n, resetn, done, cause, x.e, x.rn, x.dn, x.cs);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (edge_n > 0) begin
      if ({resetn1, done1} !== prev1) begin
        n_cmp++;
        if (ev1_q.size() == 0) begin
          n_bad++;
          $display("FAIL ch1_unexpected: edge %0d got resetn=%b done=%b, required no change",
                   edge_n, resetn1, done1);
        end else begin
          x = ev1_q.pop_front();
          if (x.e != edge_n || x.rn[0] !== resetn1[0] || x.dn !== done1 || x.cs !== cause1) begin
            n_bad++;
            $display("FAIL ch1_event: got edge %0d resetn=%b done=%b cause=%b, required edge %0d resetn=%b done=%b cause=%b",
                     edge_n, resetn1, done1, cause1, x.e, x.rn[0], x.dn, x.cs);
          end
        end
      end else if (ev1_q.size() > 0 && ev1_q[0].e <= edge_n) begin
        x = ev1_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL ch1_missing: edge %0d got resetn=%b done=%b, required resetn=%b done=%b",
                 edge_n, resetn1, done1, x.rn[0], x.dn);
      end
      prev1 = {resetn1, done1};
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while ((ev_q.size() + snap_q.size() + ev1_q.size()) > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: edge %0d got %0d pending expectations, required 0",
               edge_n, ev_q.size() + snap_q.size() + ev1_q.size());
      ev_q.delete();
      snap_q.delete();
      ev1_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int a;

    // Power-on: rst high for edges 1..3.
    push_snap(1, 3'b000, 1'b0, 4'b0001);
    repeat (3) @(negedge clk);
    push_seq(edge_n);
    push_ev1(edge_n + 8, 1'b1, 1'b1, 4'b0001);
    rst  = 1'b0;
    rst1 = 1'b0;
    wait_idle();
    push_snap(edge_n + 1, 3'b111, 1'b1, 4'b0001);
    @(negedge clk);

    // One-cycle PLL lock loss in RUN; the 1-channel instance is parked in reset.
    a = edge_n + 1;
    push_ev(a + 2, 3'b000, 1'b0);
    push_snap(a + 2, 3'b000, 1'b0, 4'b0011);
    push_seq(a + 2);
    push_ev1(a, 1'b0, 1'b0, 4'b0001);
    rst1       = 1'b1;
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    wait_idle();

    // cause_clr alone.
    push_snap(edge_n + 1, 3'b111, 1'b1, 4'b0000);
    cause_clr = 1'b1;
    @(negedge clk);
    cause_clr = 1'b0;
    wait_idle();

    // Button bounce with 3-cycle pulses must not reset.
    for (int i = 0; i < 2; i++) begin
      ext_req = 1'b1;
      repeat (3) @(negedge clk);
      ext_req = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    push_snap(edge_n + 1, 3'b111, 1'b1, 4'b0000);
    @(negedge clk);

    // Button held 6 cycles: asserts 7 edges after the hold starts.
    a = edge_n + 1;
    push_ev(a + 6, 3'b000, 1'b0);
    push_snap(a + 6, 3'b000, 1'b0, 4'b0100);
    push_seq(a + 11);
    ext_req = 1'b1;
    repeat (6) @(negedge clk);
    ext_req = 1'b0;
    wait_idle();

    // sw_req in RUN, then again one cycle after ch0 releases.
    a = edge_n + 1;
    push_ev(a, 3'b000, 1'b0);
    push_snap(a, 3'b000, 1'b0, 4'b1100);
    push_ev(a + 8, 3'b001, 1'b0);
    push_ev(a + 9, 3'b000, 1'b0);
    push_seq(a + 9);
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    repeat (8) @(negedge clk);
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    wait_idle();

    // cause_clr together with sw_req: sw bit survives.
    a = edge_n + 1;
    push_ev(a, 3'b000, 1'b0);
    push_snap(a, 3'b000, 1'b0, 4'b1000);
    push_seq(a);
    sw_req    = 1'b1;
    cause_clr = 1'b1;
    @(negedge clk);
    sw_req    = 1'b0;
    cause_clr = 1'b0;
    wait_idle();

    // sw_req held 3 cycles behaves as a level.
    a = edge_n + 1;
    push_ev(a, 3'b000, 1'b0);
    push_seq(a + 2);
    sw_req = 1'b1;
    repeat (3) @(negedge clk);
    sw_req = 1'b0;
    wait_idle();

    // Single-cycle rst in RUN reloads the cause register.
    a = edge_n + 1;
    push_ev(a, 3'b000, 1'b0);
    push_snap(a, 3'b000, 1'b0, 4'b0001);
    push_seq(a);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
